// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the instruction-fetch and data buses.
// One outstanding transaction, round-robin on ties, timeout abort with error.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ok,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [3:0]  d_wstrb,
   input  logic [31:0] d_wdata,
   output logic        d_ok,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_wdata,
   input  logic        m_ok,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              lastD_q, lastD_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              we_q, we_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       wdata_q, wdata_d;

   logic grantD, grantI, timeoutHit, done;

   // On a tie the side that did not win last time is served; lastD_q=0 means I won last.
   assign grantD     = d_req && (!i_req || !lastD_q);
   assign grantI     = i_req && !grantD;
   assign timeoutHit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
   assign done       = m_ok || timeoutHit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         lastD_q <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         lastD_q <= lastD_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lastD_d = lastD_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (grantD) begin
               state_d = GNT_D;
               lastD_d = 1'b1;
               cnt_d   = '0;
               addr_d  = d_addr;
               we_d    = d_we;
               wstrb_d = d_we ? d_wstrb : 4'b0000;
               wdata_d = d_wdata;
            end else if (grantI) begin
               state_d = GNT_I;
               lastD_d = 1'b0;
               cnt_d   = '0;
               addr_d  = i_addr;
               we_d    = 1'b0;
               wstrb_d = 4'b0000;
            end
         end
         GNT_I, GNT_D: begin
            if (done) begin
               state_d = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Completion is decoded from the current state so the winner sees ok in the m_ok cycle.
   always_comb begin
      i_ok    = 1'b0;
      i_err   = 1'b0;
      i_rdata = '0;
      d_ok    = 1'b0;
      d_err   = 1'b0;
      d_rdata = '0;
      if (state_q == GNT_I) begin
         i_ok    = done;
         i_err   = !m_ok && timeoutHit;
         i_rdata = (m_ok && !we_q) ? m_rdata : 32'h0;
      end else if (state_q == GNT_D) begin
         d_ok    = done;
         d_err   = !m_ok && timeoutHit;
         d_rdata = (m_ok && !we_q) ? m_rdata : 32'h0;
      end
   end

   assign m_req   = (state_q != IDLE);
   assign m_addr  = addr_q;
   assign m_we    = we_q;
   assign m_wstrb = wstrb_q;
   assign m_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected transactions are queued when
// requests are driven and checked as the memory side completes them.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        resetn;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ok;
   logic        i_err;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr;
   logic        d_we;
   logic [3:0]  d_wstrb;
   logic [31:0] d_wdata;
   logic        d_ok;
   logic        d_err;
   logic [31:0] d_rdata;
   logic        m_req;
   logic [31:0] m_addr;
   logic        m_we;
   logic [3:0]  m_wstrb;
   logic [31:0] m_wdata;
   logic        m_ok;
   logic [31:0] m_rdata;

   typedef struct {
      logic        isD;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } txn_t;

   txn_t expQ[$];
   int   nAssert = 0;
   int   nFail   = 0;

   mem_bus_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_ok(i_ok), .i_err(i_err), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
      .d_ok(d_ok), .d_err(d_err), .d_rdata(d_rdata),
      .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
      .m_ok(m_ok), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      nAssert++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(logic isD, logic [31:0] addr, logic we, logic [3:0] wstrb,
                          logic [31:0] wdata);
      txn_t t;
      t.isD   = isD;
      t.addr  = addr;
      t.we    = we;
      t.wstrb = wstrb;
      t.wdata = wdata;
      expQ.push_back(t);
   endtask

   task automatic applyStimulus(logic isD, logic [31:0] addr, logic we, logic [3:0] wstrb,
                                logic [31:0] wdata);
      if (isD) begin
         d_req   = 1'b1;
         d_addr  = addr;
         d_we    = we;
         d_wstrb = wstrb;
         d_wdata = wdata;
      end else begin
         i_req  = 1'b1;
         i_addr = addr;
      end
   endtask

   // Wait for the grant, hold m_ok low for lat cycles, then complete (or let it time out).
   task automatic serviceOne(int lat, logic [31:0] memData, bit expTimeout, bit dropReq,
                             int maxWait);
      txn_t        t;
      int          waited;
      logic [31:0] expRdata;
      waited = 0;
      if (expQ.size() == 0) begin
         $display("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
         $fatal(1, "[TB] scoreboard underflow");
      end
      t = expQ.pop_front();
      while (!m_req && waited < maxWait) begin
         step();
         waited++;
      end
      checkOutput("m_req_grant", 32'(m_req), 32'd1);
      checkOutput("m_addr", m_addr, t.addr);
      checkOutput("m_we", 32'(m_we), 32'(t.we));
      checkOutput("m_wstrb", 32'(m_wstrb), 32'(t.wstrb));
      if (t.we) checkOutput("m_wdata", m_wdata, t.wdata);
      for (int c = 0; c < lat; c++) begin
         checkOutput("no_early_ok", 32'({i_ok, d_ok}), 32'd0);
         step();
         checkOutput("m_req_held", 32'(m_req), 32'd1);
      end
      m_ok    = !expTimeout;
      m_rdata = memData;
      #1;
      expRdata = (expTimeout || t.we) ? 32'h0 : memData;
      if (t.isD) begin
         checkOutput("d_ok", 32'(d_ok), 32'd1);
         checkOutput("d_err", 32'(d_err), 32'(expTimeout));
         checkOutput("d_rdata", d_rdata, expRdata);
         checkOutput("i_side_quiet", {30'd0, i_ok, i_err} | i_rdata, 32'd0);
         if (dropReq) d_req = 1'b0;
      end else begin
         checkOutput("i_ok", 32'(i_ok), 32'd1);
         checkOutput("i_err", 32'(i_err), 32'(expTimeout));
         checkOutput("i_rdata", i_rdata, expRdata);
         checkOutput("d_side_quiet", {30'd0, d_ok, d_err} | d_rdata, 32'd0);
         if (dropReq) i_req = 1'b0;
      end
      step();
      m_ok    = 1'b0;
      m_rdata = 32'h0;
      #1;
      checkOutput("idle_bubble_m_req", 32'(m_req), 32'd0);
      checkOutput("idle_bubble_ok", 32'({i_ok, d_ok}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn  = 1'b1;
      i_req   = 1'b0;
      i_addr  = 32'h0;
      d_req   = 1'b0;
      d_addr  = 32'h0;
      d_we    = 1'b0;
      d_wstrb = 4'h0;
      d_wdata = 32'h0;
      m_ok    = 1'b0;
      m_rdata = 32'h0;
      #1 resetn = 1'b0;
      #1;
      checkOutput("rst_m_req", 32'(m_req), 32'd0);
      checkOutput("rst_oks", 32'({i_ok, i_err, d_ok, d_err}), 32'd0);
      checkOutput("rst_rdata", i_rdata | d_rdata, 32'd0);
      checkOutput("rst_m_fields", m_addr | m_wdata | 32'({m_we, m_wstrb}), 32'd0);
      step();
      step();
      #2 resetn = 1'b1;
      step();

      // m_ok while idle must not produce a completion
      m_ok    = 1'b1;
      m_rdata = 32'h5A5A5A5A;
      #1;
      checkOutput("idle_mok_ignored", 32'({i_ok, d_ok, m_req}), 32'd0);
      checkOutput("idle_mok_rdata", i_rdata | d_rdata, 32'd0);
      step();
      m_ok    = 1'b0;
      m_rdata = 32'h0;

      // Tie after reset: D, I, D, I with strobes masked on loads
      applyStimulus(1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'hCAFE_0000);
      applyStimulus(1'b0, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
      pushExp(1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0);
      pushExp(1'b0, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
      pushExp(1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0);
      pushExp(1'b0, 32'h0000_0100, 1'b0, 4'h0, 32'h0);
      serviceOne(1, 32'hAAAA_0001, 1'b0, 1'b0, 1);
      serviceOne(1, 32'hAAAA_0002, 1'b0, 1'b0, 1);
      serviceOne(1, 32'hAAAA_0003, 1'b0, 1'b1, 1);
      serviceOne(1, 32'hAAAA_0004, 1'b0, 1'b1, 1);

      // Single fetch from the boot vector
      applyStimulus(1'b0, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0);
      pushExp(1'b0, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0);
      serviceOne(2, 32'h2408_0001, 1'b0, 1'b1, 1);

      // Store: read data must be suppressed
      applyStimulus(1'b1, 32'h8000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      pushExp(1'b1, 32'h8000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      serviceOne(1, 32'h1234_5678, 1'b0, 1'b1, 1);

      // Timeout on a load with a fetch arriving during the hung grant
      applyStimulus(1'b1, 32'h0000_0300, 1'b0, 4'h0, 32'h0);
      pushExp(1'b1, 32'h0000_0300, 1'b0, 4'h0, 32'h0);
      pushExp(1'b0, 32'h0000_0400, 1'b0, 4'h0, 32'h0);
      step();
      applyStimulus(1'b0, 32'h0000_0400, 1'b0, 4'h0, 32'h0);
      serviceOne(3, 32'h0, 1'b1, 1'b1, 0);
      serviceOne(0, 32'h0BAD_F00D, 1'b0, 1'b1, 1);

      // m_ok on the timeout cycle wins
      applyStimulus(1'b1, 32'h0000_0304, 1'b0, 4'h0, 32'h0);
      pushExp(1'b1, 32'h0000_0304, 1'b0, 4'h0, 32'h0);
      serviceOne(3, 32'h7777_1234, 1'b0, 1'b1, 1);

      // Reset in the middle of a fetch grant
      applyStimulus(1'b0, 32'h0000_0500, 1'b0, 4'h0, 32'h0);
      step();
      checkOutput("midrst_granted", 32'(m_req), 32'd1);
      #2 resetn = 1'b0;
      #1;
      checkOutput("midrst_m_req", 32'(m_req), 32'd0);
      checkOutput("midrst_no_ok", 32'({i_ok, i_err}), 32'd0);
      checkOutput("midrst_m_addr", m_addr, 32'h0);
      applyStimulus(1'b1, 32'h0000_0600, 1'b0, 4'h0, 32'h0);
      pushExp(1'b1, 32'h0000_0600, 1'b0, 4'h0, 32'h0);
      pushExp(1'b0, 32'h0000_0500, 1'b0, 4'h0, 32'h0);
      step();
      checkOutput("midrst_held_low", 32'(m_req), 32'd0);
      #2 resetn = 1'b1;
      serviceOne(1, 32'h6666_0001, 1'b0, 1'b1, 1);
      serviceOne(1, 32'h5555_0001, 1'b0, 1'b1, 1);

      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
